wb_sram: RTL

Wishbone B4 pipelined responder: a single-port, byte-lane-enabled word SRAM with a configurable fixed access latency. It sits at the far end of the data-bus interface driven by the loadstore unit. Instruction-fetch buses can also use it, as the memory model for core-level benches and the on-chip data RAM. It accepts at most one outstanding request when LATENCY > 1, and one request per cycle when LATENCY = 1.

---
 rtl/wb_sram_if.sv | 22 ++
 rtl/wb_sram.sv | 113 +++++++++++
 2 files changed

// File: rtl/wb_sram_if.sv
// Wishbone B4 pipelined bus bundle between a requester (master) and the wb_sram responder (slave).
interface wb_sram_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_stall_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/wb_sram.sv
// Byte-lane word SRAM, Wishbone B4 pipelined; ack LATENCY cycles after accept, stall only from registered state.
// WB_SRAM_RANDOM_STALL_EN adds LFSR-driven stall injection in IDLE/ACK to exercise requester stall paths.
module wb_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wb_sram_if.slave bus
);
  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [31:0]    hold_q, hold_d;
  logic [31:0]    rdata_q;
  logic [31:0]    dat_out;
  logic           stall;
  logic           accept;
  logic [AW-1:0]  idx;
  logic           unused_adr;
  logic [31:0]    mem [DEPTH_WORDS];

  // Upper and byte-offset address bits alias onto the same word.
  assign idx        = bus.wb_adr_i[AW+1:2];
  assign unused_adr = ^{bus.wb_adr_i[31:AW+2], bus.wb_adr_i[1:0]};

`ifdef WB_SRAM_RANDOM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall  = (state_q == WAIT) | (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign stall = (state_q == WAIT);
`endif

  // Reset also blocks acceptance so nothing is written in a reset cycle.
  assign accept = bus.wb_cyc_i & bus.wb_stb_i & ~stall & ~rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    if (accept) we_d = bus.wb_we_i;

    dat_out = hold_q;
    if (state_q == ACK) dat_out = we_q ? 32'h0 : rdata_q;
    hold_d = dat_out;

    unique case (state_q)
      WAIT: begin
        if (!bus.wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = ACK;
        end
      end
      default: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
    end
  end

  // Storage is not reset; the read word is captured at accept and held for the ack.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (bus.wb_we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.wb_sel_i[b]) mem[idx][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
        end
      end
      rdata_q <= mem[idx];
    end
  end

  assign bus.wb_ack_o   = (state_q == ACK);
  assign bus.wb_stall_o = stall;
  assign bus.wb_dat_o   = dat_out;
endmodule
